ad_ip_jesd204_tpl_dac_channel_src: RTL and testbench

Per-channel DAC sample-source stage in the JESD204 DAC transport layer. It sits directly downstream of the DAC register map and consumes that map's per-channel `dac_data_sel`, `dac_mask_enable` and `dac_pat_data_0/1` controls. Each beat it selects or generates DATA_PATH_WIDTH 16-bit samples from DDS, DMA, a constant pattern, PN7/PN15, a ramp or zero, and feeds the framer. It also produces the underflow pulse that the register map latches as `dac_dunf`.

---
 rtl/ad_ip_jesd204_tpl_dac_channel_src.sv | 109 ++++++++++
 tb/tb_ad_ip_jesd204_tpl_dac_channel_src.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ad_ip_jesd204_tpl_dac_channel_src.sv
// ad_ip_jesd204_tpl_dac_channel_src: per-channel DAC sample source (DDS/DMA/pattern/PN7/PN15/ramp/zero)
module ad_ip_jesd204_tpl_dac_channel_src #(
    parameter int DATA_PATH_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [3:0]                    dac_data_sel,
    input  logic                          dac_mask_enable,
    input  logic [15:0]                   dac_pat_data_0,
    input  logic [15:0]                   dac_pat_data_1,
    input  logic                          dac_sync,
    input  logic [DATA_PATH_WIDTH*16-1:0] dds_data,
    input  logic [DATA_PATH_WIDTH*16-1:0] dma_data,
    input  logic                          dma_valid,
    output logic                          dma_ready,
    output logic [DATA_PATH_WIDTH*16-1:0] dac_data,
    output logic                          dac_dunf
);
    localparam int W = DATA_PATH_WIDTH * 16;

    // Sequence bit i lands in sample i/16, MSB first; returns {final_state, data}.
    function automatic logic [W+6:0] pn7_run(input logic [6:0] seed);
        logic [6:0]   s;
        logic [W-1:0] d;
        s = seed;
        d = '0;
        for (int i = 0; i < W; i++) begin
            d[16*(i/16)+15-(i%16)] = s[6];
            s = {s[5:0], s[6] ^ s[5]};
        end
        return {s, d};
    endfunction

    function automatic logic [W+14:0] pn15_run(input logic [14:0] seed);
        logic [14:0]  s;
        logic [W-1:0] d;
        s = seed;
        d = '0;
        for (int i = 0; i < W; i++) begin
            d[16*(i/16)+15-(i%16)] = s[14];
            s = {s[13:0], s[14] ^ s[13]};
        end
        return {s, d};
    endfunction

    logic [6:0]   pn7, pn7_eff, pn7_nxt;
    logic [14:0]  pn15, pn15_eff, pn15_nxt;
    logic [15:0]  ramp, ramp_eff, ramp_nxt;
    logic         par, par_eff, par_nxt;
    logic [3:0]   prev_sel;
    logic         restart, dunf_nxt;
    logic [W-1:0] pn7_data, pn15_data, ramp_data, pat_data, data_nxt;

    assign restart   = dac_sync | (dac_data_sel != prev_sel);
    assign dma_ready = ~reset & dac_mask_enable & (dac_data_sel == 4'd2);
    assign dunf_nxt  = dma_ready & ~dma_valid;

    always_comb begin
        pn7_eff   = restart ? 7'h7F : pn7;
        pn15_eff  = restart ? 15'h7FFF : pn15;
        ramp_eff  = restart ? 16'h0 : ramp;
        par_eff   = restart ? 1'b0 : par;
        {pn7_nxt, pn7_data}   = pn7_run(pn7_eff);
        {pn15_nxt, pn15_data} = pn15_run(pn15_eff);
        ramp_nxt  = ramp_eff + 16'(DATA_PATH_WIDTH);
        par_nxt   = par_eff ^ 1'(DATA_PATH_WIDTH % 2);
        ramp_data = '0;
        pat_data  = '0;
        for (int k = 0; k < DATA_PATH_WIDTH; k++) begin
            ramp_data[16*k +: 16] = ramp_eff + 16'(k);
            pat_data[16*k +: 16]  = (((k % 2) == 1) ^ par_eff) ? dac_pat_data_1 : dac_pat_data_0;
        end
        case (dac_data_sel)
            4'd0:    data_nxt = dds_data;
            4'd1:    data_nxt = pat_data;
            4'd2:    data_nxt = dma_valid ? dma_data : '0;
            4'd4:    data_nxt = pn7_data;
            4'd5:    data_nxt = pn15_data;
            4'd6:    data_nxt = ramp_data;
            default: data_nxt = '0;
        endcase
        if (!dac_mask_enable) data_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dac_data <= '0;
            dac_dunf <= 1'b0;
            pn7      <= 7'h7F;
            pn15     <= 15'h7FFF;
            ramp     <= 16'h0;
            par      <= 1'b0;
            prev_sel <= 4'hF;
        end else begin
            dac_data <= data_nxt;
            dac_dunf <= dunf_nxt;
            prev_sel <= dac_data_sel;
            // Idle generators hold, but a sync still re-seeds them.
            if (dac_mask_enable && dac_data_sel == 4'd4) pn7 <= pn7_nxt;
            else if (dac_sync) pn7 <= 7'h7F;
            if (dac_mask_enable && dac_data_sel == 4'd5) pn15 <= pn15_nxt;
            else if (dac_sync) pn15 <= 15'h7FFF;
            if (dac_mask_enable && dac_data_sel == 4'd6) ramp <= ramp_nxt;
            else if (dac_sync) ramp <= 16'h0;
            if (dac_mask_enable && dac_data_sel == 4'd1) par <= par_nxt;
            else if (dac_sync) par <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_channel_src.sv
// tb_ad_ip_jesd204_tpl_dac_channel_src: directed scoreboard bench for the DAC channel source
module tb_ad_ip_jesd204_tpl_dac_channel_src;
    localparam int DPW = 4;
    localparam int W = DPW * 16;
    localparam int NB = 2048;

    logic          clk = 0;
    logic          reset = 1;
    logic [3:0]    dac_data_sel = 0;
    logic          dac_mask_enable = 0;
    logic [15:0]   dac_pat_data_0 = 0, dac_pat_data_1 = 0;
    logic          dac_sync = 0;
    logic [W-1:0]  dds_data = 0, dma_data = 0;
    logic          dma_valid = 0;
    logic          dma_ready;
    logic [W-1:0]  dac_data;
    logic          dac_dunf;

    int checks = 0, errors = 0;
    logic [W-1:0] exp_q[$];
    logic         dunf_q[$];
    logic         seq7[NB], seq15[NB];
    int           p7 = 0, p15 = 0;

    ad_ip_jesd204_tpl_dac_channel_src #(.DATA_PATH_WIDTH(DPW)) dut (
        .clk(clk), .reset(reset), .dac_data_sel(dac_data_sel), .dac_mask_enable(dac_mask_enable),
        .dac_pat_data_0(dac_pat_data_0), .dac_pat_data_1(dac_pat_data_1), .dac_sync(dac_sync),
        .dds_data(dds_data), .dma_data(dma_data), .dma_valid(dma_valid), .dma_ready(dma_ready),
        .dac_data(dac_data), .dac_dunf(dac_dunf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Push expectation for the inputs currently driven, clock once, pop and compare.
    task automatic beat(input string tag, input logic [W-1:0] e, input logic ed);
        logic [W-1:0] xe;
        logic         xd;
        exp_q.push_back(e);
        dunf_q.push_back(ed);
        @(posedge clk);
        #1;
        xe = exp_q.pop_front();
        xd = dunf_q.pop_front();
        chk({tag, "_data"}, dac_data, xe);
        chk({tag, "_dunf"}, W'(dac_dunf), W'(xd));
    endtask

    function automatic logic [W-1:0] ramp_word(input int base);
        logic [W-1:0] r;
        for (int k = 0; k < DPW; k++) r[16*k +: 16] = 16'(base + k);
        return r;
    endfunction

    // Pull next 16*DPW bits from a precomputed sequence, MSB-first per sample.
    function automatic logic [W-1:0] pn_word(input logic is15, inout int p);
        logic [W-1:0] r;
        for (int k = 0; k < DPW; k++)
            for (int b = 15; b >= 0; b--) begin
                r[16*k+b] = is15 ? seq15[p] : seq7[p];
                p++;
            end
        return r;
    endfunction

    initial begin
        for (int n = 0; n < NB; n++) begin
            seq7[n]  = (n < 7)  ? 1'b1 : seq7[n-7] ^ seq7[n-6];
            seq15[n] = (n < 15) ? 1'b1 : seq15[n-15] ^ seq15[n-14];
        end
        dac_data_sel = 2;
        dac_mask_enable = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", W'(dma_ready), '0);
        chk("reset_data", dac_data, '0);
        chk("reset_dunf", W'(dac_dunf), '0);

        reset = 0;
        dac_data_sel = 6;
        beat("ramp0", 64'h0003_0002_0001_0000, 0);
        beat("ramp1", 64'h0007_0006_0005_0004, 0);
        for (int n = 2; n <= 16384; n++) beat("ramp_run", ramp_word(4 * n), 0);
        beat("ramp_after_wrap", ramp_word(4), 0);

        reset = 1;
        beat("ramp_reset", '0, 0);
        reset = 0;
        beat("ramp_restart", 64'h0003_0002_0001_0000, 0);
        dac_mask_enable = 0;
        beat("ramp_masked", '0, 0);
        dac_mask_enable = 1;
        beat("ramp_unmask", 64'h0007_0006_0005_0004, 0);

        dac_data_sel = 1;
        dac_pat_data_0 = 16'h1234;
        dac_pat_data_1 = 16'hABCD;
        repeat (3) beat("pattern", 64'hABCD_1234_ABCD_1234, 0);

        dac_data_sel = 4;
        p7 = 0;
        repeat (3) beat("pn7", pn_word(0, p7), 0);
        dac_sync = 1;
        p7 = 0;
        beat("pn7_sync", pn_word(0, p7), 0);
        dac_sync = 0;
        repeat (2) beat("pn7_after_sync", pn_word(0, p7), 0);

        dac_data_sel = 5;
        p15 = 0;
        repeat (4) beat("pn15", pn_word(1, p15), 0);

        dac_data_sel = 2;
        dma_valid = 1;
        for (int i = 1; i <= 3; i++) begin
            dma_data = {16'(i + 3), 16'(i + 2), 16'(i + 1), 16'(i)};
            #1;
            chk("dma_ready", W'(dma_ready), W'(1));
            beat("dma", {16'(i + 3), 16'(i + 2), 16'(i + 1), 16'(i)}, 0);
        end
        dma_valid = 0;
        beat("dma_underflow", '0, 1);
        dma_valid = 1;
        dma_data = 64'h0123_4567_89AB_CDEF;
        beat("dma_resume", 64'h0123_4567_89AB_CDEF, 0);

        dac_mask_enable = 0;
        dma_valid = 0;
        #1;
        chk("masked_ready", W'(dma_ready), '0);
        beat("dma_masked", '0, 0);
        dac_mask_enable = 1;
        dac_data_sel = 9;
        beat("reserved", '0, 0);
        dac_data_sel = 0;
        dds_data = 64'hDEAD_BEEF_0BAD_F00D;
        beat("dds", 64'hDEAD_BEEF_0BAD_F00D, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
